// File: rtl/stage_join_fifo_pkg.sv
// Shared defaults and helpers for the RMT stage join buffer.
// Imported by the channel FIFO and the join top.
package stage_join_fifo_pkg;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_DATA_W = 1024;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_AFULL  = 3;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/stage_join_fifo_ch.sv
// One elastic channel: register-array FIFO with fall-through read,
// registered occupancy, ready and almost-full.
module stage_join_fifo_ch
    import stage_join_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_LVL = DEF_AFULL,
    localparam int CNT_W    = cnt_w(DEPTH),
    localparam int PTR_W    = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  level,
    output logic              afull,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign s_ready = ~full;
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    assign push   = s_valid & s_ready & ~flush;
    assign do_pop = pop & ~empty & ~flush;

    always_comb begin
        cnt_nxt = count;
        unique case ({push, do_pop})
            2'b10:   cnt_nxt = count + CNT_W'(1);
            2'b01:   cnt_nxt = count - CNT_W'(1);
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            afull  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= cnt_nxt;
            afull <= (cnt_nxt >= CNT_W'(AFULL_LVL));
        end
    end

    // Storage is cleared on reset only so m_data reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

endmodule

// File: rtl/stage_join_fifo.sv
// Elastic join of NUM_CH valid/ready streams into one output beat,
// with joint pop fanout and a sticky full-vs-empty skew flag.
module stage_join_fifo
    import stage_join_fifo_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_LVL = DEF_AFULL,
    localparam int CNT_W    = cnt_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_valid,
    output logic [NUM_CH-1:0]        s_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [NUM_CH*CNT_W-1:0]  level,
    output logic [NUM_CH-1:0]        afull,
    output logic                     skew_err
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic              pop;
    logic              skew_hit;

    assign m_valid = ~|empty;
    assign pop     = m_valid & m_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        stage_join_fifo_ch #(
            .DATA_W    (DATA_W),
            .DEPTH     (DEPTH),
            .AFULL_LVL (AFULL_LVL)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .s_data  (s_data[g*DATA_W +: DATA_W]),
            .s_valid (s_valid[g]),
            .s_ready (s_ready[g]),
            .pop     (pop),
            .rd_data (m_data[g*DATA_W +: DATA_W]),
            .level   (level[g*CNT_W +: CNT_W]),
            .afull   (afull[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );
    end

    // A full lane facing an empty one can never drain: likely deadlock.
    always_comb begin
        skew_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            for (int j = 0; j < NUM_CH; j++)
                if (i != j && full[i] && empty[j])
                    skew_hit = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            skew_err <= 1'b0;
        else if (skew_hit)
            skew_err <= 1'b1;
    end

endmodule
